// File: rtl/game_pkg.sv
// Shared game-wide definitions for the fighter controller and its bench.
// Contents:
//   SCREEN_W / SCREEN_H : visible raster size in pixels
//   BOX_W               : fighter box width in pixels
//   atk_state_t         : attack phase encoding seen by the renderer
//   max3()              : helper used to size the phase frame counter
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BOX_W    = 10;

  typedef enum logic [1:0] {
    ATK_IDLE     = 2'd0,
    ATK_STARTUP  = 2'd1,
    ATK_ACTIVE   = 2'd2,
    ATK_RECOVERY = 2'd3
  } atk_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fighter_ctrl_if.sv
// Bundle between the raster stage (master) and the fighter controller (slave).
// Signals:
//   frame_tick              : 1-cycle pulse on the last pixel of each frame
//   btn_up / btn_dn         : move right / left while held
//   btn_fire                : attack button, edge-triggered across frame samples
//   pos_x[9:0]              : fighter box left edge X
//   atk_state[1:0]          : 0 IDLE, 1 STARTUP, 2 ACTIVE, 3 RECOVERY
//   hit_active              : high only while ACTIVE
//   busy                    : high in any non-IDLE phase
interface fighter_ctrl_if;

  logic       frame_tick;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_fire;
  logic [9:0] pos_x;
  logic [1:0] atk_state;
  logic       hit_active;
  logic       busy;

  modport master (
    output frame_tick, btn_up, btn_dn, btn_fire,
    input  pos_x, atk_state, hit_active, busy
  );

  modport slave (
    input  frame_tick, btn_up, btn_dn, btn_fire,
    output pos_x, atk_state, hit_active, busy
  );

endinterface

// File: rtl/fighter_ctrl.sv
// Per-frame player controller feeding the raster renderer.
// Samples the buttons once per frame (on frame_tick), moves the fighter box
// horizontally with saturation and runs the STARTUP/ACTIVE/RECOVERY attack
// sequence. All outputs are registered and only change on a tick edge, so
// they are stable for a whole visible frame.
// Ports:
//   clk_pix : pixel clock
//   sim_rst : asynchronous active-high reset
//   bus     : fighter_ctrl_if.slave (tick, buttons in; pos/attack status out)
module fighter_ctrl
  import game_pkg::*;
#(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = SCREEN_W - BOX_W,
  parameter int START_X     = 315,
  parameter int STEP        = 2,
  parameter int STARTUP_FR  = 5,
  parameter int ACTIVE_FR   = 3,
  parameter int RECOVERY_FR = 8
) (
  input  logic           clk_pix,
  input  logic           sim_rst,
  fighter_ctrl_if.slave  bus
);

  localparam int MAX_PH = max3(STARTUP_FR, ACTIVE_FR, RECOVERY_FR);
  localparam int CNT_W  = $clog2(MAX_PH + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_STARTUP  = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_RECOVERY = 2'd3;

  localparam logic [10:0] X_MIN11  = 11'(X_MIN);
  localparam logic [10:0] X_MAX11  = 11'(X_MAX);
  localparam logic [10:0] STEP11   = 11'(STEP);
  localparam logic [9:0]  START10  = 10'(START_X);

  logic             run_q;
  logic             primed_q;
  logic             fire_prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pos_q, pos_d;
  logic             hit_q, busy_q;

  logic             tick;
  logic             fire_edge;
  logic [10:0]      sum11;
  logic [9:0]       pos_up, pos_dn;

  // run_q only rises on the first clock after reset release, so a tick that
  // lands on the release edge is ignored. primed_q blocks a fire edge on the
  // first tick after reset: a button already held through reset must be
  // released and pressed again before it can trigger an attack.
  assign tick      = bus.frame_tick & run_q;
  assign fire_edge = bus.btn_fire & ~fire_prev_q & primed_q;

  // Saturating moves done in 11 bits so neither direction can wrap.
  assign sum11  = {1'b0, pos_q} + STEP11;
  assign pos_up = (sum11 > X_MAX11) ? X_MAX11[9:0] : sum11[9:0];
  assign pos_dn = ({1'b0, pos_q} < (X_MIN11 + STEP11)) ? X_MIN11[9:0]
                                                        : (pos_q - STEP11[9:0]);

  // Next-state logic. Movement only happens in IDLE, and a triggering frame
  // does not move. In the attack phases cnt counts frames left in the phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          state_d = S_STARTUP;
          cnt_d   = CNT_W'(STARTUP_FR - 1);
        end else if (bus.btn_up && !bus.btn_dn) begin
          pos_d = pos_up;
        end else if (bus.btn_dn && !bus.btn_up) begin
          pos_d = pos_dn;
        end
      end
      S_STARTUP: begin
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
          cnt_d   = CNT_W'(ACTIVE_FR - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = S_RECOVERY;
          cnt_d   = CNT_W'(RECOVERY_FR - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Frame-rate registers. hit/busy are decoded from the next state so they
  // line up with atk_state in the same frame.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      run_q       <= 1'b0;
      primed_q    <= 1'b0;
      fire_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pos_q       <= START10;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (tick) begin
        primed_q    <= 1'b1;
        fire_prev_q <= bus.btn_fire;
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        pos_q       <= pos_d;
        hit_q       <= (state_d == S_ACTIVE);
        busy_q      <= (state_d != S_IDLE);
      end
    end
  end

  assign bus.pos_x      = pos_q;
  assign bus.atk_state  = state_q;
  assign bus.hit_active = hit_q;
  assign bus.busy       = busy_q;

endmodule
